uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_sampler.sv | 47 ++++
 rtl/uart_rx_cfg.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {NONE, ODD, EVEN} parity_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_t;

    function automatic int clk_per_samp(input int clk_hz, input int baud, input int spb);
        return clk_hz / (baud * spb);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchroniser, sample-tick generator and 3-tap majority vote.
module uart_rx_sampler #(
    parameter int CLK_PER_SAMP = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rx,
    input  logic restart_i,
    output logic tick_o,
    output logic bit_maj_o,
    output logic fall_o
);
    import uart_pkg::*;

    localparam int CW = CLK_PER_SAMP > 1 ? $clog2(CLK_PER_SAMP) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             samp_q;
    logic                   tick_now, tick_q, prev_q, line;

    assign line      = sync_q[SYNC_STAGES-1];
    assign fall_o    = prev_q & ~line;
    assign tick_now  = cnt_q == CW'(CLK_PER_SAMP - 1);
    assign cnt_d     = (restart_i || tick_now) ? '0 : cnt_q + 1'b1;
    assign tick_o    = tick_q;
    assign bit_maj_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // tick_o is delayed one clock so the shift register already holds the newest sample
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '1;
            cnt_q  <= '0;
            samp_q <= '1;
            tick_q <= 1'b0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            cnt_q  <= cnt_d;
            samp_q <= tick_now ? {samp_q[1:0], line} : samp_q;
            tick_q <= tick_now & ~restart_i;
            prev_q <= line;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with majority sampling, parity/framing/break/overrun
// detection and a one-entry valid/ready holding register.
module uart_rx_cfg #(
    parameter int CLK_HZ       = 65_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int SAMP_PER_BIT = 16,
    parameter int CLK_PER_SAMP = uart_pkg::clk_per_samp(CLK_HZ, BAUD_RATE, SAMP_PER_BIT),
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err
);
    import uart_pkg::*;

    localparam int      SW  = $clog2(SAMP_PER_BIT);
    localparam int      BW  = $clog2(DATA_BITS + 1);
    localparam parity_t PAR = parity_t'(PARITY);

    rx_state_t            state_q, state_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 perr_pend_q, perr_pend_d, ferr_pend_q, ferr_pend_d;
    logic                 par_bit_q, par_bit_d, stop0_q, stop0_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 brk_q, brk_d, ovr_q, ovr_d;
    logic                 tick, bit_maj, fall, restart, mid, par_exp, brk_cond, load;

    uart_rx_sampler #(
        .CLK_PER_SAMP(CLK_PER_SAMP),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rx       (rx),
        .restart_i(restart),
        .tick_o   (tick),
        .bit_maj_o(bit_maj),
        .fall_o   (fall)
    );

    assign restart  = state_q == IDLE && fall;
    assign mid      = tick && (samp_q == (state_q == START ? SW'(SAMP_PER_BIT / 2 - 1) : SW'(SAMP_PER_BIT - 1)));
    assign par_exp  = (^shift_q) ^ (PAR == ODD);
    assign brk_cond = (shift_q == '0) && (PAR == NONE || !par_bit_q) && !stop0_q;
    assign load     = state_q == DONE && (!valid_q || ready_in);

    always_comb begin
        state_d     = state_q;
        samp_d      = mid ? '0 : (tick ? samp_q + 1'b1 : samp_q);
        bit_d       = bit_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        par_bit_d   = par_bit_q;
        stop0_d     = stop0_q;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    samp_d  = '0;
                end
            end
            START: begin
                if (mid) begin
                    state_d     = bit_maj ? IDLE : DATA;
                    bit_d       = '0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            DATA: begin
                if (mid) begin
                    shift_d = {bit_maj, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = PAR == NONE ? STOP : uart_pkg::PARITY;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (mid) begin
                    par_bit_d   = bit_maj;
                    perr_pend_d = bit_maj != par_exp;
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (mid) begin
                    stop0_d     = bit_q == '0 ? bit_maj : stop0_q;
                    ferr_pend_d = ferr_pend_q | ~bit_maj;
                    bit_d       = bit_q + 1'b1;
                    state_d     = bit_q == BW'(STOP_BITS - 1) ? DONE : STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a frame arriving while the held one is still unclaimed is dropped
    assign valid_d = load | (valid_q & ~ready_in);
    assign data_d  = load ? shift_q : data_q;
    assign perr_d  = load ? perr_pend_q : perr_q;
    assign ferr_d  = load ? ferr_pend_q : ferr_q;
    assign brk_d   = state_q == DONE && brk_cond;
    assign ovr_d   = ovr_q | (state_q == DONE && !load);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            par_bit_q   <= 1'b0;
            stop0_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            par_bit_q   <= par_bit_d;
            stop0_q     <= stop0_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign break_det   = brk_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: drives an 8N1 and a 7E2 receiver with directed and random frames and
// checks them against frames built from the line-format rules.
module tb_uart_rx_cfg;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx8 = 1'b1, rx7 = 1'b1, ready8 = 1'b1, ready7 = 1'b1;
    logic [7:0] data8;
    logic [6:0] data7;
    logic       valid8, perr8, ferr8, brk8, ovr8;
    logic       valid7, perr7, ferr7, brk7, ovr7;
    logic       v8_prev = 1'b0;
    frm_t       q8[$], q7[$];
    int         errors = 0, checks = 0, cyc = 0, t0 = 0, rise8 = 0, nbrk8 = 0, nbrk7 = 0;

    uart_rx_cfg #(
        .CLK_HZ(6_400_000), .BAUD_RATE(100_000), .SAMP_PER_BIT(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
    ) dut8 (
        .clk_in(clk), .rst_in(rst), .rx(rx8), .data_out(data8), .valid_out(valid8),
        .ready_in(ready8), .parity_err(perr8), .frame_err(ferr8), .break_det(brk8),
        .overrun_err(ovr8)
    );

    uart_rx_cfg #(
        .CLK_HZ(6_400_000), .BAUD_RATE(100_000), .SAMP_PER_BIT(16),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)
    ) dut7 (
        .clk_in(clk), .rst_in(rst), .rx(rx7), .data_out(data7), .valid_out(valid7),
        .ready_in(ready7), .parity_err(perr7), .frame_err(ferr7), .break_det(brk7),
        .overrun_err(ovr7)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // accepted frames, first-valid time and break pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (valid8 && ready8) q8.push_back('{d: {1'b0, data8}, pe: perr8, fe: ferr8});
        if (valid7 && ready7) q7.push_back('{d: {2'b0, data7}, pe: perr7, fe: ferr7});
        if (valid8 && !v8_prev) rise8 <= cyc;
        v8_prev <= valid8;
        if (brk8) nbrk8 <= nbrk8 + 1;
        if (brk7) nbrk7 <= nbrk7 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit sel7, input logic v);
        if (sel7) rx7 = v;
        else rx8 = v;
    endtask

    // 64 clocks per bit; spike >= 0 puts a 2-clock low pulse mid-way through that frame bit
    task automatic send(input bit sel7, input logic [8:0] d, input logic flip,
                        input logic [1:0] stops, input int spike);
        logic [11:0] bits;
        int n;
        int nd;
        bits = '0;
        n = 0;
        nd = sel7 ? 7 : 8;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < nd; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (sel7) begin
            bits[n] = 1'($countones(d[6:0]) % 2) ^ flip;
            n++;
        end
        bits[n] = stops[0];
        n++;
        if (sel7) begin
            bits[n] = stops[1];
            n++;
        end
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            drive(sel7, bits[k]);
            if (k == spike) begin
                wait_clk(30);
                drive(sel7, 1'b0);
                wait_clk(2);
                drive(sel7, bits[k]);
                wait_clk(32);
            end else begin
                wait_clk(64);
            end
        end
        drive(sel7, 1'b1);
    endtask

    task automatic expect_frame(input string tag, input bit sel7, input logic [8:0] d,
                                input logic pe, input logic fe);
        frm_t f;
        int sz;
        sz = sel7 ? q7.size() : q8.size();
        check({tag, ".count"}, sz, 1);
        if (sz > 0) begin
            if (sel7) f = q7.pop_front();
            else f = q8.pop_front();
            check({tag, ".data"}, f.d, d);
            check({tag, ".parity_err"}, f.pe, pe);
            check({tag, ".frame_err"}, f.fe, fe);
        end
        if (sel7) q7.delete();
        else q8.delete();
    endtask

    initial begin
        logic [7:0] d8;
        logic [6:0] d7;
        logic       stp, flip;
        logic [1:0] stops;
        int         gap, b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        check("rst.valid8", valid8, 0);
        check("rst.data8", data8, 0);
        check("rst.flags8", {perr8, ferr8, brk8, ovr8}, 0);
        check("rst.valid7", valid7, 0);

        send(0, 9'h0A5, 0, 2'b11, -1);
        wait_clk(64);
        expect_frame("a5", 0, 9'h0A5, 0, 0);
        check("a5.latency_in_stop_bit", (rise8 - t0 >= 608) && (rise8 - t0 < 640), 1);
        check("a5.overrun", ovr8, 0);
        check("a5.breaks", nbrk8, 0);

        send(1, 9'h035, 0, 2'b11, -1);
        wait_clk(64);
        expect_frame("7e2_ok", 1, 9'h035, 0, 0);
        send(1, 9'h035, 1, 2'b11, -1);
        wait_clk(64);
        expect_frame("7e2_flip", 1, 9'h035, 1, 0);

        rx8 = 1'b0;
        wait_clk(20);
        rx8 = 1'b1;
        wait_clk(128);
        check("glitch.frames", q8.size(), 0);
        check("glitch.valid", valid8, 0);

        send(0, 9'h00F, 0, 2'b11, 3);
        wait_clk(64);
        expect_frame("spike", 0, 9'h00F, 0, 0);

        send(0, 9'h03C, 0, 2'b10, -1);
        wait_clk(64);
        expect_frame("stop_low", 0, 9'h03C, 0, 1);
        check("stop_low.breaks", nbrk8, 0);

        rx8 = 1'b0;
        wait_clk(768);
        check("break.frames_while_low", q8.size(), 1);
        rx8 = 1'b1;
        wait_clk(128);
        expect_frame("break", 0, 9'h000, 0, 1);
        check("break.pulses", nbrk8, 1);

        ready8 = 1'b0;
        send(0, 9'h011, 0, 2'b11, -1);
        wait_clk(64);
        send(0, 9'h022, 0, 2'b11, -1);
        wait_clk(64);
        check("ovr.valid", valid8, 1);
        check("ovr.data_held", data8, 8'h11);
        check("ovr.flag", ovr8, 1);
        ready8 = 1'b1;
        @(negedge clk);
        check("ovr.valid_at_accept", valid8, 1);
        @(negedge clk);
        check("ovr.valid_dropped", valid8, 0);
        wait_clk(1);
        expect_frame("ovr", 0, 9'h011, 0, 0);

        rx8 = 1'b0;
        wait_clk(64);
        rx8 = 1'b0;
        wait_clk(64);
        rx8 = 1'b1;
        wait_clk(64);
        rx8 = 1'b0;
        wait_clk(20);
        rst = 1'b1;
        rx8 = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(700);
        check("midrst.valid", valid8, 0);
        check("midrst.data", data8, 0);
        check("midrst.flags", {perr8, ferr8, brk8, ovr8}, 0);
        check("midrst.frames", q8.size(), 0);
        send(0, 9'h05A, 0, 2'b11, -1);
        wait_clk(64);
        expect_frame("after_rst", 0, 9'h05A, 0, 0);

        for (int i = 0; i < 16; i++) begin
            d8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            stp = $urandom_range(0, 3) != 0;
            gap = $urandom_range(1, 3);
            b0 = nbrk8;
            send(0, {1'b0, d8}, 0, {1'b1, stp}, -1);
            wait_clk(64 * gap);
            expect_frame("rnd8", 0, {1'b0, d8}, 0, !stp);
            check("rnd8.breaks", nbrk8 - b0, (d8 == 8'h00) && !stp);
        end

        for (int i = 0; i < 16; i++) begin
            d7 = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            flip = 1'($urandom);
            stops = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            gap = $urandom_range(1, 3);
            b0 = nbrk7;
            send(1, {2'b0, d7}, flip, stops, -1);
            wait_clk(64 * gap);
            expect_frame("rnd7", 1, {2'b0, d7}, flip, stops != 2'b11);
            check("rnd7.breaks", nbrk7 - b0, (d7 == 7'h00) && !flip && !stops[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
